// File: rtl/oursring_pkg.sv
// Shared types for the oursring station data protocol.
package oursring_pkg;
    localparam logic [1:0] ST_RD  = 2'd0;
    localparam logic [1:0] ST_WR  = 2'd1;
    localparam logic [1:0] ST_RSP = 2'd2;
    localparam logic [1:0] ST_ERR = 2'd3;

    typedef struct packed {
        logic [1:0]  typ;
        logic [39:0] addr;
        logic [63:0] data;
    } sd_info_t;
endpackage

// File: rtl/oursring_sd_responder_if.sv
// Ring request/response channels plus the local register bus of one station responder.
interface oursring_sd_responder_if;
    import oursring_pkg::*;

    logic        req_valid;
    logic        req_ready;
    sd_info_t    req_info;
    logic        rsp_valid;
    logic        rsp_ready;
    sd_info_t    rsp_info;
    logic        bus_req;
    logic        bus_we;
    logic [39:0] bus_addr;
    logic [63:0] bus_wdata;
    logic        bus_ack;
    logic        bus_err;
    logic [63:0] bus_rdata;

    modport slave (
        input  req_valid, req_info, rsp_ready, bus_ack, bus_err, bus_rdata,
        output req_ready, rsp_valid, rsp_info, bus_req, bus_we, bus_addr, bus_wdata
    );

    modport master (
        output req_valid, req_info, rsp_ready, bus_ack, bus_err, bus_rdata,
        input  req_ready, rsp_valid, rsp_info, bus_req, bus_we, bus_addr, bus_wdata
    );
endinterface

// File: rtl/oursring_sd_responder.sv
// Station-side responder: one sd_info_t request at a time is turned into a local
// register-bus access with wait states and answered with a single ST_RSP/ST_ERR.
module oursring_sd_responder
    import oursring_pkg::*;
#(
    parameter logic [39:0] BASE_ADDR      = 40'h0,
    parameter logic [39:0] ADDR_MASK      = 40'hFFF,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    oursring_sd_responder_if.slave sd
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]       state_reg;
    logic [CNT_W-1:0] wait_cnt_reg;
    logic [1:0]       typ_reg;
    logic             req_ready_reg;
    logic             rsp_valid_reg;
    sd_info_t         rsp_info_reg;
    logic             bus_req_reg;
    logic             bus_we_reg;
    logic [39:0]      bus_addr_reg;
    logic [63:0]      bus_wdata_reg;

    // Non-zero means the request is rejected before any bus cycle; lower codes win.
    logic [63:0] early_code;
    always_comb begin
        early_code = 64'd0;
        if (sd.req_info.typ == ST_RSP || sd.req_info.typ == ST_ERR)
            early_code = 64'd1;
        else if ((sd.req_info.addr & ~ADDR_MASK) != BASE_ADDR)
            early_code = 64'd2;
        else if (sd.req_info.addr[2:0] != 3'd0)
            early_code = 64'd3;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            wait_cnt_reg  <= '0;
            typ_reg       <= 2'd0;
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_info_reg  <= '0;
            bus_req_reg   <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_addr_reg  <= 40'd0;
            bus_wdata_reg <= 64'd0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    req_ready_reg <= 1'b1;
                    if (sd.req_valid && req_ready_reg) begin
                        req_ready_reg <= 1'b0;
                        typ_reg       <= sd.req_info.typ;
                        bus_addr_reg  <= sd.req_info.addr;
                        bus_wdata_reg <= sd.req_info.data;
                        if (early_code != 64'd0) begin
                            state_reg     <= S_RESP;
                            rsp_valid_reg <= 1'b1;
                            rsp_info_reg  <= '{typ: ST_ERR, addr: sd.req_info.addr, data: early_code};
                        end else begin
                            state_reg    <= S_ACCESS;
                            bus_req_reg  <= 1'b1;
                            bus_we_reg   <= (sd.req_info.typ == ST_WR);
                            wait_cnt_reg <= '0;
                        end
                    end
                end
                S_ACCESS: begin
                    // Error beats ack, and ack beats the timeout on the final cycle.
                    if (sd.bus_err || sd.bus_ack || wait_cnt_reg == CNT_LAST) begin
                        state_reg         <= S_RESP;
                        bus_req_reg       <= 1'b0;
                        bus_we_reg        <= 1'b0;
                        rsp_valid_reg     <= 1'b1;
                        rsp_info_reg.addr <= bus_addr_reg;
                        if (sd.bus_err) begin
                            rsp_info_reg.typ  <= ST_ERR;
                            rsp_info_reg.data <= 64'd4;
                        end else if (sd.bus_ack) begin
                            rsp_info_reg.typ  <= ST_RSP;
                            rsp_info_reg.data <= (typ_reg == ST_RD) ? sd.bus_rdata : 64'd0;
                        end else begin
                            rsp_info_reg.typ  <= ST_ERR;
                            rsp_info_reg.data <= 64'd5;
                        end
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                S_RESP: begin
                    if (sd.rsp_ready) begin
                        state_reg     <= S_IDLE;
                        rsp_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign sd.req_ready = req_ready_reg;
    assign sd.rsp_valid = rsp_valid_reg;
    assign sd.rsp_info  = rsp_info_reg;
    assign sd.bus_req   = bus_req_reg;
    assign sd.bus_we    = bus_we_reg;
    assign sd.bus_addr  = bus_addr_reg;
    assign sd.bus_wdata = bus_wdata_reg;
endmodule

// File: tb/tb_oursring_sd_responder.sv
// Randomized scoreboard bench for oursring_sd_responder against a rule-level reference model.
module tb_oursring_sd_responder;
    import oursring_pkg::*;

    localparam int          TO   = 4;
    localparam logic [39:0] BASE = 40'h0;
    localparam logic [39:0] MASK = 40'hFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    oursring_sd_responder_if sd();

    oursring_sd_responder #(
        .BASE_ADDR(BASE),
        .ADDR_MASK(MASK),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sd(sd)
    );

    typedef struct {
        logic [1:0]  typ;
        logic [39:0] addr;
        logic [63:0] data;
        int          wt;       // bus cycles before completion is driven; >= TO means never
        bit          err;
        bit          ack_too;
        logic [63:0] rdata;
    } txn_t;

    typedef struct {
        sd_info_t rsp;
        int       cycles;
        int       hs;
    } exp_t;

    typedef struct {
        bit          we;
        logic [39:0] addr;
        logic [63:0] wdata;
        int          wt;
        bit          err;
        bit          ack_too;
        logic [63:0] rdata;
        int          cycles;
    } plan_t;

    exp_t  exp_q[$];
    plan_t plan_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    rsp_cnt = 0;
    int    hold_next = 0;
    bit    abandon = 1'b0;
    bit    resp_open = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [127:0] act, logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: what the responder must answer and how many cycles bus_req must be high.
    function automatic exp_t model(txn_t t);
        exp_t e;
        e.rsp.typ  = ST_ERR;
        e.rsp.addr = t.addr;
        e.rsp.data = 64'd0;
        e.cycles   = 0;
        e.hs       = 0;
        if (t.typ == ST_RSP || t.typ == ST_ERR) e.rsp.data = 64'd1;
        else if ((t.addr & ~MASK) != BASE)      e.rsp.data = 64'd2;
        else if (t.addr[2:0] != 3'd0)           e.rsp.data = 64'd3;
        else if (t.wt >= TO) begin
            e.rsp.data = 64'd5;
            e.cycles   = TO;
        end else begin
            e.cycles = t.wt + 1;
            if (t.err) e.rsp.data = 64'd4;
            else begin
                e.rsp.typ  = ST_RSP;
                e.rsp.data = (t.typ == ST_RD) ? t.rdata : 64'd0;
            end
        end
        return e;
    endfunction

    function automatic txn_t mk(logic [1:0] typ, logic [39:0] addr, logic [63:0] data,
                                int wt, bit err, bit ack_too, logic [63:0] rdata);
        txn_t t;
        t.typ = typ; t.addr = addr; t.data = data; t.wt = wt;
        t.err = err; t.ack_too = ack_too; t.rdata = rdata;
        return t;
    endfunction

    task automatic send(txn_t t);
        exp_t  e;
        plan_t p;
        int    n;
        e = model(t);
        n = 0;
        @(negedge clk);
        sd.req_valid = 1'b1;
        sd.req_info  = '{typ: t.typ, addr: t.addr, data: t.data};
        while (!sd.req_ready) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                errors++;
                $display("FAIL req_accept actual=no_handshake required=handshake_within_200");
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $fatal(1, "request handshake never happened");
            end
        end
        e.hs = cyc + 1;
        exp_q.push_back(e);
        if (e.cycles > 0) begin
            p.we = (t.typ == ST_WR); p.addr = t.addr; p.wdata = t.data;
            p.wt = t.wt; p.err = t.err; p.ack_too = t.ack_too; p.rdata = t.rdata;
            p.cycles = e.cycles;
            plan_q.push_back(p);
        end
        @(negedge clk);
        sd.req_valid = 1'b0;
        sd.req_info  = '{typ: 2'($urandom), addr: {8'($urandom), $urandom}, data: {$urandom, $urandom}};
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || resp_open) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 128'(exp_q.size()) + 128'(resp_open), 128'd0);
    endtask

    // Response-side backpressure, with occasional long stalls.
    initial begin : rsp_ready_drv
        int hold;
        hold = 0;
        sd.rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hold_next > 0) begin
                hold = hold_next;
                hold_next = 0;
            end
            if (hold > 0) begin
                hold--;
                sd.rsp_ready = 1'b0;
            end else if ($urandom_range(0, 19) == 0) begin
                hold = 10;
                sd.rsp_ready = 1'b0;
            end else begin
                sd.rsp_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Bus slave: follows the plan of the current access, drives junk outside it.
    initial begin : bus_model
        plan_t p;
        int    n;
        bit    in_acc;
        bit    stray;
        in_acc = 1'b0; stray = 1'b0; n = 0;
        sd.bus_ack = 1'b0; sd.bus_err = 1'b0; sd.bus_rdata = 64'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_acc = 1'b0;
                sd.bus_ack = 1'b0; sd.bus_err = 1'b0;
            end else if (sd.bus_req) begin
                if (!in_acc) begin
                    in_acc = 1'b1;
                    n = 0;
                    checks++;
                    if (plan_q.size() == 0) begin
                        errors++;
                        stray = 1'b1;
                        p.wt = 1000;
                        $display("FAIL bus_req_unexpected actual=1 required=0 (cycle %0d)", cyc);
                    end else begin
                        stray = 1'b0;
                        p = plan_q.pop_front();
                    end
                end
                if (!stray)
                    check("bus_fields", {sd.bus_we, sd.bus_addr, sd.bus_wdata}, {p.we, p.addr, p.wdata});
                n++;
                sd.bus_rdata = {$urandom, $urandom};
                if (n == p.wt + 1) begin
                    sd.bus_err   = p.err;
                    sd.bus_ack   = p.err ? p.ack_too : 1'b1;
                    sd.bus_rdata = p.rdata;
                end else begin
                    sd.bus_ack = 1'b0;
                    sd.bus_err = 1'b0;
                end
            end else begin
                if (in_acc) begin
                    in_acc = 1'b0;
                    if (!abandon && !stray) check("bus_req_cycles", 128'(n), 128'(p.cycles));
                end
                sd.bus_ack   = 1'($urandom);
                sd.bus_err   = 1'($urandom);
                sd.bus_rdata = {$urandom, $urandom};
            end
        end
    end

    // Response monitor: pops the scoreboard on each new response, checks it every held cycle.
    initial begin : rsp_monitor
        exp_t cur;
        bit   stray;
        stray = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                resp_open = 1'b0;
                continue;
            end
            if (sd.rsp_valid || sd.bus_req) check("req_ready_busy", 128'(sd.req_ready), 128'd0);
            if (sd.rsp_valid) begin
                if (!resp_open) begin
                    resp_open = 1'b1;
                    rsp_cnt++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        stray = 1'b1;
                        $display("FAIL rsp_unexpected actual=%0h required=none", sd.rsp_info);
                    end else begin
                        stray = 1'b0;
                        cur = exp_q.pop_front();
                        check("rsp_latency", 128'(cyc - cur.hs), 128'(cur.cycles));
                    end
                    $display("RSP %0d typ=%0d addr=%h data=%h", rsp_cnt,
                             sd.rsp_info.typ, sd.rsp_info.addr, sd.rsp_info.data);
                end
                if (!stray) check("rsp_info", 128'(sd.rsp_info), 128'(cur.rsp));
                if (sd.rsp_ready) resp_open = 1'b0;
            end
        end
    end

    initial begin : main
        txn_t t;
        int   r;
        sd.req_valid = 1'b0;
        sd.req_info  = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {sd.req_ready, sd.rsp_valid, sd.bus_req, sd.bus_we}, 4'b0000);
        check("reset_rsp_info", 128'(sd.rsp_info), 128'd0);
        check("reset_bus_data", {sd.bus_addr, sd.bus_wdata}, 104'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 128'(sd.req_ready), 128'd1);

        // Directed cases: zero-wait read under a long stall, waited write acked on the
        // final cycle, early errors, bus error with ack, timeout.
        hold_next = 14;
        send(mk(ST_RD,  40'h10,   64'h0,    0,  1'b0, 1'b0, 64'hDEADBEEF_CAFEF00D));
        send(mk(ST_WR,  40'h8,    64'h1234, 3,  1'b0, 1'b0, 64'h5555));
        send(mk(ST_RSP, 40'h10,   64'h77,   0,  1'b0, 1'b0, 64'h0));
        send(mk(ST_RD,  40'h1000, 64'h0,    0,  1'b0, 1'b0, 64'h0));
        send(mk(ST_RD,  40'h4,    64'h0,    0,  1'b0, 1'b0, 64'h0));
        send(mk(ST_RD,  40'h18,   64'h0,    1,  1'b1, 1'b1, 64'hAAAA));
        send(mk(ST_WR,  40'h20,   64'h99,   10, 1'b0, 1'b0, 64'h0));
        send(mk(ST_ERR, 40'h28,   64'h0,    0,  1'b0, 1'b0, 64'h0));

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            t.typ = (r < 4) ? ST_RD : (r < 8) ? ST_WR : (r == 8) ? ST_RSP : ST_ERR;
            r = $urandom_range(0, 9);
            if (r == 0)      t.addr = {8'($urandom), $urandom};
            else if (r == 1) t.addr = (40'($urandom_range(0, 511)) << 3) | 40'($urandom_range(1, 7));
            else             t.addr = 40'($urandom_range(0, 511)) << 3;
            t.data    = {$urandom, $urandom};
            t.wt      = $urandom_range(0, 5);
            t.err     = ($urandom_range(0, 5) == 0);
            t.ack_too = 1'($urandom);
            t.rdata   = {$urandom, $urandom};
            send(t);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        // Reset on the second access cycle abandons the transaction.
        send(mk(ST_RD, 40'h30, 64'h0, 100, 1'b0, 1'b0, 64'h0));
        @(negedge clk);
        abandon = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("reset_mid_access", {sd.bus_req, sd.rsp_valid, sd.req_ready}, 3'b000);
        exp_q.delete();
        plan_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_mid_reset", 128'(sd.req_ready), 128'd1);
        abandon = 1'b0;
        repeat (5) @(negedge clk);

        send(mk(ST_RD, 40'h38, 64'h0, 0, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF));
        drain();
        check("plan_q_empty", 128'(plan_q.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/oursring_sd_responder.md
# oursring_sd_responder

Target-side responder for the oursring station data (`sd_info_t`) protocol. It accepts one `ST_RD` or `ST_WR` request at a time and performs the access on a local register bus with wait states. It then returns a single `sd_info_t` response of type `ST_RSP` (success) or `ST_ERR` (failure, with an error code). The block sits at a ring station, between the ring-side request/response channels and the station's register file.

## Interface
Parameters:
- `BASE_ADDR`, default `40'h0`: base of the decoded address window.
- `ADDR_MASK`, default `40'hFFF`: window offset mask. An address hits when `(addr & ~ADDR_MASK) == BASE_ADDR`.
- `TIMEOUT_CYCLES`, default `256`: maximum bus wait. Legal range 2..65535.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request valid.
- `req_ready` out 1: request ready.
- `req_info` in `sd_info_t`: request `{typ, addr, data}`.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response ready.
- `rsp_info` out `sd_info_t`: response.
- `bus_req` out 1: local bus request, held until completion.
- `bus_we` out 1: 1 = write.
- `bus_addr` out 40: access address.
- `bus_wdata` out 64: write data.
- `bus_ack` in 1: access complete.
- `bus_err` in 1: access failed. Qualified only while `bus_req` is high.
- `bus_rdata` in 64: read data. Valid with `bus_ack`.

## Operation
State machine with three states: IDLE, ACCESS, RESP.

IDLE:
- `req_ready` = 1.
- On the handshake `req_valid & req_ready`, latch `req_info` into the transaction registers.
- Checks are applied in this priority order:
  1. `typ` is `ST_RSP` or `ST_ERR` → RESP with `ST_ERR`, code 1.
  2. Address misses the window → RESP with `ST_ERR`, code 2.
  3. `addr[2:0] != 0` → RESP with `ST_ERR`, code 3.
  4. Otherwise → ACCESS.
- On an error exit, `bus_req` is never asserted.

ACCESS:
- `bus_req` = 1.
- `bus_we` = (`typ == ST_WR`).
- `bus_addr` = latched addr; `bus_wdata` = latched data.
- These values are stable for the whole state.
- Wait counter: cleared on ACCESS entry, increments each ACCESS cycle without a completion.
- Completions:
  - `bus_err` → RESP `ST_ERR`, code 4. `bus_err` beats `bus_ack` when both are high in the same cycle.
  - `bus_ack` → RESP `ST_RSP`. Response data = `bus_rdata` for RD, 64'h0 for WR.
  - Counter reaches `TIMEOUT_CYCLES-1` with no ack/err → RESP `ST_ERR`, code 5. An ack on that same final cycle wins over the timeout.
- Counter width is `$clog2(TIMEOUT_CYCLES)`.

RESP:
- `rsp_valid` = 1.
- `rsp_info.addr` = request addr.
- `rsp_info.data` = read data, 0, or error code (zero-extended to 64 bits).
- `rsp_info` is held stable until `rsp_ready`.
- On `rsp_valid & rsp_ready` → IDLE.

General rules:
- Only one transaction is outstanding. `req_ready` = 0 in ACCESS and RESP.
- All outputs are registered or decoded directly from the state register. No input-to-output combinational path except none.

Reset:
- While `rst` is high: state = IDLE; `req_ready`, `rsp_valid`, `bus_req`, `bus_we` = 0; `rsp_info`, `bus_addr`, `bus_wdata` = 0.
- `req_ready` = 1 on the first cycle after `rst` deasserts.
- Reset mid-transaction abandons it: `bus_req` drops at that edge and no response is produced.

## Timing
- Request accepted at edge T → `bus_req` high from cycle T+1.
- Bus completion sampled at edge A → `rsp_valid` high from cycle A+1 and `bus_req` low from A+1.
- Zero-wait bus (ack in the first ACCESS cycle): request handshake to `rsp_valid` = 2 cycles.
- Early error (codes 1–3): `rsp_valid` from cycle T+1; no bus cycle.
- Timeout: `bus_req` is high for exactly `TIMEOUT_CYCLES` cycles, then `rsp_valid` follows on the next cycle.
- Response handshake at edge R → `req_ready` high from R+1.
- Peak throughput: one transaction per 3 cycles with a zero-wait bus and `rsp_ready` held high.
- `rsp_ready` may be held low indefinitely. The responder holds RESP and accepts nothing new.

## Test plan
- Read, in window, zero-wait: `req {ST_RD, 40'h10, x}`, `bus_ack` with `bus_rdata = 64'hDEADBEEF_CAFEF00D` in the first ACCESS cycle → `bus_we` = 0; `rsp {ST_RSP, 40'h10, 64'hDEADBEEF_CAFEF00D}` two cycles after the request handshake.
- Write with 3 wait states: `req {ST_WR, 40'h8, 64'h1234}` → `bus_req` high 4 cycles with `bus_we` = 1 and `bus_wdata = 64'h1234`; `rsp {ST_RSP, 40'h8, 0}`.
- Early errors, no bus cycle: `typ = ST_RSP` → code 1; addr `40'h1000` → code 2; addr `40'h4` → code 3; in every case `bus_req` stays 0.
- Bus error and timeout:
  - `bus_err` together with `bus_ack` → `ST_ERR`, code 4.
  - With `TIMEOUT_CYCLES` = 4 and no ack → `bus_req` high exactly 4 cycles, then `ST_ERR`, code 5.
  - Ack on the 4th cycle → `ST_RSP`.
- Backpressure: `rsp_ready` low for 10 cycles → `rsp_info` stable throughout, `req_ready` = 0, a new `req_valid` is not accepted.
- Reset mid-ACCESS: assert `rst` on the second ACCESS cycle → `bus_req` = 0 after the edge, no response, `req_ready` = 1 one cycle after `rst` drops.
